// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared definitions for the 68000-style bus initiator.
//   - bus_state_e : bus-cycle sequencer states
//   - ERR_*       : rsp_err completion codes
//   - DEV_*       : chip-select codes shared with the board address decoder
//   - ds_n_from_be: byte enables -> active-low {UDS, LDS}
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ASRT,
        WRDS,
        WAIT,
        DONE,
        RECOV
    } bus_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BERR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam logic [1:0] DEV_ROM  = 2'b00;
    localparam logic [1:0] DEV_RAM  = 2'b01;
    localparam logic [1:0] DEV_IO   = 2'b10;
    localparam logic [1:0] DEV_NONE = 2'b11;

    // Width of the WAIT-state timeout counter; TIMEOUT is limited to 2..255.
    localparam int unsigned TO_CNT_W = 8;

    // be[1] selects UDS (D15..8), be[0] selects LDS (D7..0); strobes are active-low.
    function automatic logic [1:0] ds_n_from_be(input logic [1:0] be);
        return ~be;
    endfunction

endpackage

// File: rtl/m68k_sync2.sv
// m68k_sync2: flip-flop synchroniser for an active-low asynchronous bus input.
// The chain resets to 1 so a terminated-but-released bus line reads as inactive.
//   clk16   in  clock
//   reset_n in  synchronous active-low reset
//   d_n     in  asynchronous active-low input
//   q_n     out synchronised copy
module m68k_sync2 #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk16,
    input  logic reset_n,
    input  logic d_n,
    output logic q_n
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d_n};
        end
    end

    assign q_n = sync_ff[STAGES-1];

endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: turns one valid/ready request into a single 68000-style
// asynchronous bus cycle (AS/UDS/LDS/RW) terminated by DTACK, BERR or timeout.
//   clk16, reset_n                 clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_addr/we/be/wdata           word address, direction, byte lanes, write data
//   rsp_valid/rsp_rdata/rsp_err    completion pulse, last good read data, status
//   bus_addr, bus_addr_oe          address and address/strobe drive enable
//   as_n, uds_n, lds_n, rw         bus strobes and direction (rw=1 read)
//   bus_data_o/oe, bus_data_i      data bus out/enable/in
//   dtack_n, berr_n                asynchronous terminations
// All outputs are registered; each state's outputs are set on the edge that enters it.
module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk16,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [22:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [22:0] bus_addr,
    output logic        bus_addr_oe,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    output logic        rw,
    output logic [15:0] bus_data_o,
    output logic        bus_data_oe,
    input  logic [15:0] bus_data_i,
    input  logic        dtack_n,
    input  logic        berr_n
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    bus_state_e          state;
    logic [1:0]          be_lat;
    logic                we_lat;
    logic [TO_CNT_W-1:0] to_cnt;
    logic                dtack_s;
    logic                berr_s;

    m68k_sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_sync_dtack (
        .clk16   (clk16),
        .reset_n (reset_n),
        .d_n     (dtack_n),
        .q_n     (dtack_s)
    );

    m68k_sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_sync_berr (
        .clk16   (clk16),
        .reset_n (reset_n),
        .d_n     (berr_n),
        .q_n     (berr_s)
    );

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= ERR_OK;
            rsp_rdata   <= '0;
            bus_addr    <= '0;
            bus_addr_oe <= 1'b0;
            as_n        <= 1'b1;
            uds_n       <= 1'b1;
            lds_n       <= 1'b1;
            rw          <= 1'b1;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
            be_lat      <= '0;
            we_lat      <= 1'b0;
            to_cnt      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        bus_addr   <= req_addr;
                        bus_data_o <= req_wdata;
                        be_lat     <= req_be;
                        we_lat     <= req_we;
                        if (req_be == 2'b00) begin
                            // No lane selected: report and skip the bus cycle entirely.
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_ILLEGAL;
                        end else begin
                            state       <= ADDR;
                            bus_addr_oe <= 1'b1;
                            rw          <= ~req_we;
                        end
                    end
                end
                ADDR: begin
                    state <= ASRT;
                    as_n  <= 1'b0;
                    if (we_lat) begin
                        // Data is put on the bus a cycle before the data strobes.
                        bus_data_oe <= 1'b1;
                    end else begin
                        {uds_n, lds_n} <= ds_n_from_be(be_lat);
                    end
                end
                ASRT: begin
                    to_cnt <= '0;
                    if (we_lat) begin
                        state          <= WRDS;
                        {uds_n, lds_n} <= ds_n_from_be(be_lat);
                    end else begin
                        state <= WAIT;
                    end
                end
                WRDS: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (!berr_s || !dtack_s || (to_cnt == TO_LAST)) begin
                        state     <= DONE;
                        as_n      <= 1'b1;
                        uds_n     <= 1'b1;
                        lds_n     <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                    // BERR takes priority over a DTACK seen on the same edge.
                    if (!berr_s) begin
                        rsp_err <= ERR_BERR;
                    end else if (!dtack_s) begin
                        rsp_err <= ERR_OK;
                        if (!we_lat) begin
                            rsp_rdata <= bus_data_i;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_err <= ERR_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_err == ERR_ILLEGAL) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state       <= RECOV;
                        bus_data_oe <= 1'b0;
                    end
                end
                RECOV: begin
                    // Hold the address phase until the responder releases both lines.
                    if (dtack_s && berr_s) begin
                        state       <= IDLE;
                        bus_addr_oe <= 1'b0;
                        rw          <= 1'b1;
                        req_ready   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed bench with a response scoreboard, a responder
// model keyed on the data strobes, and a bus trace for strobe-timing checks.
module tb_m68k_bus_master;
    import m68k_bus_pkg::*;

    logic        clk16 = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [22:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_be = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [22:0] bus_addr;
    logic        bus_addr_oe;
    logic        as_n, uds_n, lds_n, rw;
    logic [15:0] bus_data_o;
    logic        bus_data_oe;
    logic [15:0] bus_data_i = '0;
    logic        dtack_n = 1'b1;
    logic        berr_n = 1'b1;

    m68k_bus_master #(
        .TIMEOUT     (64),
        .SYNC_STAGES (2)
    ) dut (
        .clk16       (clk16),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_be      (req_be),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_addr    (bus_addr),
        .bus_addr_oe (bus_addr_oe),
        .as_n        (as_n),
        .uds_n       (uds_n),
        .lds_n       (lds_n),
        .rw          (rw),
        .bus_data_o  (bus_data_o),
        .bus_data_oe (bus_data_oe),
        .bus_data_i  (bus_data_i),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n)
    );

    always #5 clk16 = ~clk16;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk16) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: lat counts clock edges from the accepting edge (edge 1) to the
    // edge that raises rsp_valid.
    typedef struct {
        logic [1:0]  err;
        logic [15:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk16) begin
        #1;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0d expected no response",
                         rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                check("rsp_latency", cyc - mon_e.acc + 1, mon_e.lat);
                check("strobes_in_done", {29'd0, as_n, uds_n, lds_n}, 32'h7);
            end
        end
    end

    // Responder: asserts DTACK and/or BERR dly falling edges after a data strobe goes low.
    int          dly = 0;
    bit          en_dtack = 1'b1;
    bit          en_berr = 1'b0;
    bit          hold = 1'b0;
    logic [15:0] rd_val = '0;
    int          ds_cnt = 0;

    always @(negedge clk16) begin
        if (!as_n && (!uds_n || !lds_n)) begin
            if (ds_cnt >= dly) begin
                if (en_dtack) dtack_n = 1'b0;
                if (en_berr) berr_n = 1'b0;
                bus_data_i = rd_val;
            end
            ds_cnt++;
        end else begin
            ds_cnt = 0;
            if (!hold) begin
                dtack_n = 1'b1;
                berr_n = 1'b1;
            end
        end
    end

    // Bus trace sampled just after each rising edge.
    int          as_fall, uds_fall, doe_rise;
    bit          lds_low, as_low, rw_low, doe_after_done;
    int          rd_strobe_bad;
    int          rw_glitch = 0;
    int          doe_in_read = 0;
    logic [22:0] addr_at_as;
    logic [15:0] data_at_doe;
    logic        prev_as = 1'b1, prev_uds = 1'b1, prev_doe = 1'b0, prev_rw = 1'b1;
    logic        prev_rsp = 1'b0;

    task automatic clear_trace();
        as_fall = -1;
        uds_fall = -2;
        doe_rise = -3;
        lds_low = 1'b0;
        as_low = 1'b0;
        rw_low = 1'b0;
        doe_after_done = 1'b1;
        rd_strobe_bad = 0;
        addr_at_as = '0;
        data_at_doe = '0;
    endtask

    always @(posedge clk16) begin
        #1;
        if (!as_n && prev_as) begin
            as_fall = cyc;
            addr_at_as = bus_addr;
        end
        if (!uds_n && prev_uds) uds_fall = cyc;
        if (bus_data_oe && !prev_doe) begin
            doe_rise = cyc;
            data_at_doe = bus_data_o;
        end
        if (!lds_n) lds_low = 1'b1;
        if (!as_n) as_low = 1'b1;
        if (!rw) rw_low = 1'b1;
        if (!as_n && !prev_as && (rw !== prev_rw)) rw_glitch++;
        if (bus_data_oe && rw) doe_in_read++;
        if (!as_n && rw && (uds_n || lds_n)) rd_strobe_bad++;
        if (prev_rsp) doe_after_done = bus_data_oe;
        prev_as = as_n;
        prev_uds = uds_n;
        prev_doe = bus_data_oe;
        prev_rw = rw;
        prev_rsp = rsp_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk16);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got req_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic issue(input logic [22:0] a, input logic we, input logic [1:0] be,
                         input logic [15:0] wd, input logic [1:0] err,
                         input logic [15:0] rdata, input int lat);
        @(negedge clk16);
        wait_ready();
        if (req_ready) begin
            req_valid = 1'b1;
            req_addr = a;
            req_we = we;
            req_be = be;
            req_wdata = wd;
            sb_q.push_back('{err, rdata, lat, cyc + 1});
            @(posedge clk16);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk16);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_wait: got %0d pending responses expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"},
              {22'd0, as_n, uds_n, lds_n, rw, bus_addr_oe, bus_data_oe, rsp_valid, rsp_err,
               req_ready},
              32'b1111_0_0_0_00_1);
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_trace();
        repeat (3) @(posedge clk16);
        #1;
        check_reset_vals("reset");
        @(negedge clk16);
        reset_n = 1'b1;

        // Read, DTACK 3 strobe-cycles late: 5 + 3 edges.
        clear_trace();
        dly = 3;
        rd_val = 16'hBEEF;
        issue(23'h000100, 1'b0, 2'b11, 16'h0, ERR_OK, 16'hBEEF, 8);
        wait_rsp();
        check("read_addr", 32'(addr_at_as), 32'h000100);
        check("read_strobes_low", rd_strobe_bad, 0);
        check("read_rw_high", 32'(rw_low), 0);

        // Write upper byte: data_oe with AS, UDS one clock later, +1 edge over a read.
        wait_ready();
        clear_trace();
        dly = 0;
        issue(23'h080000, 1'b1, 2'b10, 16'h12AB, ERR_OK, 16'hBEEF, 6);
        wait_rsp();
        wait_ready();
        check("write_doe_in_asrt", doe_rise, as_fall);
        check("write_uds_after_as", uds_fall, as_fall + 1);
        check("write_lds_idle", 32'(lds_low), 0);
        check("write_doe_recov", 32'(doe_after_done), 0);
        check("write_data", 32'(data_at_doe), 32'h12AB);

        // Minimum read: DTACK as soon as DS falls.
        rd_val = 16'h5A5A;
        issue(23'h000200, 1'b0, 2'b01, 16'h0, ERR_OK, 16'h5A5A, 5);
        wait_rsp();

        // Timeout: WAIT entered 2 edges after accept, then 64 more.
        en_dtack = 1'b0;
        issue(23'h000300, 1'b0, 2'b11, 16'h0, ERR_TIMEOUT, 16'h5A5A, 67);
        wait_rsp();
        en_dtack = 1'b1;

        // DTACK and BERR together: BERR wins, read data untouched.
        en_berr = 1'b1;
        dly = 1;
        rd_val = 16'h1111;
        issue(23'h000400, 1'b0, 2'b11, 16'h0, ERR_BERR, 16'h5A5A, 6);
        wait_rsp();
        wait_ready();
        en_berr = 1'b0;
        dly = 0;

        // No byte lanes: immediate illegal response, AS never asserted.
        clear_trace();
        issue(23'h000500, 1'b0, 2'b00, 16'h0, ERR_ILLEGAL, 16'h5A5A, 1);
        wait_rsp();
        repeat (3) @(negedge clk16);
        check("illegal_no_as", 32'(as_low), 0);

        // Reset while waiting, then a clean read.
        en_dtack = 1'b0;
        issue(23'h000600, 1'b0, 2'b11, 16'h0, ERR_TIMEOUT, 16'h5A5A, 67);
        repeat (5) @(negedge clk16);
        reset_n = 1'b0;
        sb_q.delete();
        @(posedge clk16);
        #1;
        check_reset_vals("midreset");
        @(negedge clk16);
        reset_n = 1'b1;
        en_dtack = 1'b1;
        repeat (4) @(negedge clk16);
        rd_val = 16'h0F0F;
        issue(23'h000700, 1'b0, 2'b11, 16'h0, ERR_OK, 16'h0F0F, 5);
        wait_rsp();

        // DTACK held after DONE keeps the block in RECOV until released.
        wait_ready();
        hold = 1'b1;
        rd_val = 16'h7777;
        issue(23'h000800, 1'b0, 2'b11, 16'h0, ERR_OK, 16'h7777, 5);
        wait_rsp();
        repeat (10) @(negedge clk16);
        check("recov_hold_ready", 32'(req_ready), 0);
        check("recov_hold_addr_oe", 32'(bus_addr_oe), 1);
        hold = 1'b0;
        wait_ready();
        check("recov_release_ready", 32'(req_ready), 1);

        check("rw_stable_under_as", rw_glitch, 0);
        check("no_doe_in_read", doe_in_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m68k_bus_master.md
Name: m68k_bus_master

Overview:
- 68000-style asynchronous bus initiator: converts a simple valid/ready request port into one AS/UDS/LDS/RW bus cycle and terminates on DTACK, BERR or timeout.
- Counterpart of the board address decoder/DTACK responder; drives the same bus from the CPLD side for boot loading, DMA-style memory fill and bench exercising of the decoder.
- One outstanding transfer at a time, 16-bit data bus, byte lanes via UDS/LDS.

Parameters:
- TIMEOUT, 64, clk16 cycles in WAIT without DTACK/BERR before the cycle aborts (range 2..255).
- SYNC_STAGES, 2, flip-flop stages on dtack_n and berr_n (fixed at 2 in this revision).

Ports:
- clk16  in  1  clock
- reset_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_addr  in  23  word address A23..A1
- req_we  in  1  1 = write, 0 = read
- req_be  in  2  byte enables, [1] = UDS/D15..8, [0] = LDS/D7..0
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data, held until next read completes
- rsp_err  out  2  00 ok, 01 BERR, 10 timeout, 11 illegal request
- bus_addr  out  23  A23..A1
- bus_addr_oe  out  1  address/RW/AS/DS drive enable
- as_n, uds_n, lds_n  out  1 each  bus strobes
- rw  out  1  1 = read
- bus_data_o  out  16  write data
- bus_data_oe  out  1  data drive enable
- bus_data_i  in  16  read data
- dtack_n, berr_n  in  1 each  asynchronous terminations

Behaviour:
- Reset: reset_n is synchronous, active-low, clock clk16. Reset values: as_n=uds_n=lds_n=1, rw=1, bus_addr_oe=0, bus_data_oe=0, rsp_valid=0, rsp_err=00, rsp_rdata=0, req_ready=1, state IDLE. Reset mid-cycle returns all outputs to these values on the next edge, with no rsp_valid.
- dtack_s/berr_s: 2-FF synchronised copies of dtack_n/berr_n. All decisions use these copies only.
- Requests are accepted only when req_valid & req_ready. On acceptance, addr, we, be and wdata are latched.
- States:
  - IDLE: req_ready=1. On acceptance with be=00, go to DONE with err=11 and run no bus cycle. Otherwise go to ADDR.
  - ADDR: addr_oe=1, bus_addr and rw driven, all strobes high. Always go to ASRT.
  - ASRT: as_n=0. Read: uds_n/lds_n = ~be this cycle. Write: data_oe=1, strobes still high. Then WRDS for writes, WAIT for reads.
  - WRDS (write only): uds_n/lds_n = ~be. Go to WAIT.
  - WAIT: strobes held. Timeout counter cleared on entry and incremented each cycle.
    - berr_s=0 → DONE, err=01. BERR wins over a simultaneous DTACK.
    - else dtack_s=0 → DONE, err=00; a read latches bus_data_i into rsp_rdata on this edge.
    - else counter==TIMEOUT-1 → DONE, err=10.
  - DONE: as_n, uds_n and lds_n go high. rsp_valid=1 for exactly this cycle with rsp_err valid. Go to RECOV.
  - RECOV: data_oe=0, strobes high, addr_oe=1. Stay until dtack_s=1 and berr_s=1, so the responder has released the bus. Then go to IDLE with addr_oe=0.
  - Illegal requests pass DONE → IDLE directly and never assert any strobe.
- rsp_rdata is updated only by successful reads; errored reads leave it unchanged.
- Minimum cycle time: accept to rsp_valid = 5 clocks for a read with DTACK already low. The +2 synchroniser latency is part of this count. Writes take +1 clock.
- rw never changes while as_n=0. bus_data_oe is never 1 during a read.
- DTACK held low forever after DONE keeps the block in RECOV. This is intended: no new cycle starts until the bus is released.

Decomposition:
- Package m68k_bus_pkg holds the state encoding (IDLE, ADDR, ASRT, WRDS, WAIT, DONE, RECOV), the rsp_err codes (ERR_OK, ERR_BERR, ERR_TIMEOUT, ERR_ILLEGAL) and the DEV_* chip-select constants shared with the decoder.
- One sub-module: m68k_sync2, a 2-FF synchroniser instantiated for dtack_n and berr_n.

Test Plan:
- Read 0x000100 with be=11; responder drives DTACK low 3 clocks after AS with data 0xBEEF → rsp_valid one pulse, rsp_err=00, rsp_rdata=0xBEEF, uds_n=lds_n=0 while AS low, rw=1 throughout.
- Write 0x080000 with be=10 and wdata=0x12AB → data_oe rises in ASRT, uds_n falls one clock after as_n, lds_n stays 1. DTACK completes → err=00; data_oe=0 in RECOV.
- Read with no DTACK and TIMEOUT=64 → rsp_valid exactly 64 clocks after WAIT entry, err=10, strobes high, rsp_rdata unchanged.
- DTACK and BERR asserted on the same clock → err=01, rsp_rdata unchanged.
- Request with be=00 → rsp_valid 1 clock after accept, err=11, as_n never low.
- reset_n low while in WAIT, then a new read → outputs at reset values next edge, no rsp_valid; next read completes normally. Separately, DTACK held low after DONE holds the block in RECOV with req_ready=0.
